add_sweep_checker: RTL and testbench
====================================

ADD_SWEEP_CHECKER -- requirements
Module: add_sweep_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 3: operand width of the adder under test.
REQ-002 SHALL have parameter SETTLE, default 1, legal range 1..15: cycles each vector is held before F is sampled.
REQ-003 SHALL have clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have start  input  1  one-cycle request to begin a sweep.
REQ-006 SHALL have a  output  WIDTH  operand A driven to the adder.
REQ-007 SHALL have b  output  WIDTH  operand B driven to the adder.
REQ-008 SHALL have f  input  WIDTH+1  sum returned by the adder.
REQ-009 SHALL have busy  output  1  high while a sweep is in progress.
REQ-010 SHALL have done  output  1  high from sweep completion until the next accepted start.
REQ-011 SHALL have pass  output  1  high with done when err_count is 0.
REQ-012 SHALL have err_count  output  2*WIDTH+1  number of mismatching vectors, saturating at all-ones.
REQ-013 SHALL have first_fail  output  2*WIDTH  {a,b} of the first mismatch; 0 if none.

Function
REQ-014 SHALL implement the FSM states IDLE, DRIVE, SAMPLE and DONE.
REQ-015 In IDLE or DONE, start=1 SHALL move to DRIVE, clear the vector index n, err_count and first_fail, and drop done and pass.
REQ-016 In DRIVE or SAMPLE, start SHALL be ignored.
REQ-017 The index n (2*WIDTH bits) SHALL drive a = n[WIDTH-1:0] and b = n[2*WIDTH-1:WIDTH], so a varies fastest: 000000, 001000, ... 111111 for {a,b}.
REQ-018 DRIVE SHALL hold a and b for exactly SETTLE cycles, then enter SAMPLE.
REQ-019 SAMPLE SHALL last one cycle and compare f against a+b at full WIDTH+1 width, so the carry bit is checked (7+7 = 4'b1110).
REQ-020 On a mismatch, the block SHALL increment err_count and, if err_count was 0, capture {a,b} into first_fail.
REQ-021 When leaving SAMPLE with n not all-ones, the block SHALL increment n and return to DRIVE; with n all-ones, it SHALL enter DONE.
REQ-022 One vector SHALL take SETTLE+1 cycles, and a full sweep SHALL take 2^(2*WIDTH)*(SETTLE+1) cycles from the start edge to DONE entry.
REQ-023 busy SHALL be 1 exactly in DRIVE and SAMPLE.
REQ-024 In DONE, done SHALL be 1 and pass SHALL be (err_count==0).
REQ-025 In IDLE and DONE, a and b SHALL hold their last values.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, n=0, a=0, b=0, busy=0, done=0, pass=0, err_count=0 and first_fail=0, including mid-sweep.
REQ-027 After reset release, the block SHALL remain in IDLE until start.

Configuration
REQ-028 With macro ADD_CHK_STOP_ON_FAIL_EN defined, the first mismatch in SAMPLE SHALL enter DONE directly, leaving err_count=1.
REQ-029 Without ADD_CHK_STOP_ON_FAIL_EN, all vectors SHALL always be swept.

Verification
REQ-030 Correct combinational adder, SETTLE=1, start pulse -> busy for 128 cycles, then done=1, pass=1, err_count=0, first_fail=0.
REQ-031 Adder with f[3] stuck at 0, macro undefined -> err_count=28, first_fail=6'b111001 (a=7, b=1), pass=0.
REQ-032 Same fault with ADD_CHK_STOP_ON_FAIL_EN -> done after 16 vectors (32 cycles), err_count=1, first_fail=6'b111001.
REQ-033 rst_n pulsed low at vector 20 -> all outputs 0 asynchronously; next start sweeps from {a,b}=0.
REQ-034 start during busy -> no effect; start in DONE after failing run -> err_count and first_fail cleared, done drops next cycle.
REQ-035 SETTLE=3, adder output registered one cycle -> pass=1, done after 256 cycles.

Source files
------------

// File: rtl/add_sweep_checker_if.sv
// Bus between the exhaustive adder sweep checker and the adder under test.
// The master side is the checker; the slave side is the adder plus whoever issues start.
interface add_sweep_checker_if #(
   parameter int WIDTH = 3
);
   logic                 start;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic [WIDTH:0]       f;
   logic                 busy;
   logic                 done;
   logic                 pass;
   logic [2*WIDTH:0]     err_count;
   logic [2*WIDTH-1:0]   first_fail;

   modport master (
      input  start, f,
      output a, b, busy, done, pass, err_count, first_fail
   );

   modport slave (
      output start, f,
      input  a, b, busy, done, pass, err_count, first_fail
   );
endinterface

// File: rtl/add_sweep_checker.sv
// Exhaustive sweep of all {a,b} operand pairs against an external adder, counting mismatches.
// Optional macro ADD_CHK_STOP_ON_FAIL_EN: finish the sweep at the first mismatching vector.
module add_sweep_checker #(
   parameter int WIDTH  = 3,
   parameter int SETTLE = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   add_sweep_checker_if.master chk_io
);
   localparam int NW = 2 * WIDTH;
   localparam int EW = 2 * WIDTH + 1;

   localparam logic [NW-1:0] N_ONE       = NW'(1);
   localparam logic [NW-1:0] N_LAST      = '1;
   localparam logic [EW-1:0] ERR_ONE     = EW'(1);
   localparam logic [EW-1:0] ERR_MAX     = '1;
   localparam logic [3:0]    CNT_ONE     = 4'd1;
   localparam logic [3:0]    SETTLE_LAST = 4'(SETTLE - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [NW-1:0]   n_q, n_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [EW-1:0]   err_q, err_d;
   logic [NW-1:0]   ff_q, ff_d;

   logic [WIDTH-1:0] a_w;
   logic [WIDTH-1:0] b_w;
   logic [WIDTH:0]   sum_w;
   logic             mismatch_w;
   logic             stop_w;

   // a is the low half of the index so it steps fastest through the sweep
   assign a_w        = n_q[WIDTH-1:0];
   assign b_w        = n_q[NW-1:WIDTH];
   assign sum_w      = {1'b0, a_w} + {1'b0, b_w};
   assign mismatch_w = (chk_io.f != sum_w);

`ifdef ADD_CHK_STOP_ON_FAIL_EN
   assign stop_w = mismatch_w;
`else
   assign stop_w = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         n_q     <= '0;
         cnt_q   <= '0;
         err_q   <= '0;
         ff_q    <= '0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         ff_q    <= ff_d;
      end
   end

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      ff_d    = ff_q;
      case (state_q)
         IDLE, DONE: begin
            if (chk_io.start) begin
               state_d = DRIVE;
               n_d     = '0;
               cnt_d   = '0;
               err_d   = '0;
               ff_d    = '0;
            end
         end
         DRIVE: begin
            if (cnt_q == SETTLE_LAST) begin
               cnt_d   = '0;
               state_d = SAMPLE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         SAMPLE: begin
            if (mismatch_w) begin
               if (err_q != ERR_MAX) err_d = err_q + ERR_ONE;
               if (err_q == '0)      ff_d  = {a_w, b_w};
            end
            if (stop_w || (n_q == N_LAST)) begin
               state_d = DONE;
            end else begin
               n_d     = n_q + N_ONE;
               state_d = DRIVE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // operands come straight from the index, so they hold whenever n does
   assign chk_io.a          = a_w;
   assign chk_io.b          = b_w;
   assign chk_io.busy       = (state_q == DRIVE) || (state_q == SAMPLE);
   assign chk_io.done       = (state_q == DONE);
   assign chk_io.pass       = (state_q == DONE) && (err_q == '0);
   assign chk_io.err_count  = err_q;
   assign chk_io.first_fail = ff_q;
endmodule

// File: tb/tb_add_sweep_checker.sv
// Directed bench: good adder, f[3]-stuck-at-0 adder, reset mid-sweep, start handling, SETTLE=3 with registered adder.
module tb_add_sweep_checker;
   logic clk;
   logic rst_n;
   logic fault;
   int   total;
   int   bad;

   add_sweep_checker_if #(.WIDTH(3)) if0 ();
   add_sweep_checker_if #(.WIDTH(3)) if1 ();

   add_sweep_checker #(.WIDTH(3), .SETTLE(1)) dut0 (.clk(clk), .rst_n(rst_n), .chk_io(if0));
   add_sweep_checker #(.WIDTH(3), .SETTLE(3)) dut1 (.clk(clk), .rst_n(rst_n), .chk_io(if1));

   logic [3:0] sum0;
   assign sum0   = {1'b0, if0.a} + {1'b0, if0.b};
   assign if0.f  = fault ? (sum0 & 4'b0111) : sum0;

   logic [3:0] f1_q;
   always_ff @(posedge clk) f1_q <= {1'b0, if1.a} + {1'b0, if1.b};
   assign if1.f = f1_q;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start0();
      if0.start = 1'b1;
      step();
      if0.start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      fault = 1'b0;
      if0.start = 1'b0;
      if1.start = 1'b0;
      step();
      step();
      total++;
      if ({if0.busy, if0.done, if0.pass} !== 3'b000) begin
         bad++; $display("FAIL reset_flags got=%b want=000", {if0.busy, if0.done, if0.pass});
      end
      total++;
      if ({if0.a, if0.b, if0.err_count, if0.first_fail} !== 19'd0) begin
         bad++; $display("FAIL reset_vals a=%0d b=%0d err=%0d ff=%0d want all 0", if0.a, if0.b, if0.err_count, if0.first_fail);
      end
      rst_n = 1'b1;
      repeat (4) step();
      total++;
      if ({if0.busy, if0.done, if1.busy, if1.done} !== 4'b0000) begin
         bad++; $display("FAIL idle_hold got=%b want=0000", {if0.busy, if0.done, if1.busy, if1.done});
      end
   endtask

   task automatic run_to_done0(output int cyc);
      cyc = 0;
      while (!if0.done && cyc < 2000) begin
         step();
         cyc++;
      end
   endtask

   task automatic test_good_sweep();
      int cyc;
      pulse_start0();
      total++;
      if (if0.busy !== 1'b1 || if0.a !== 3'd0 || if0.b !== 3'd0) begin
         bad++; $display("FAIL good_first busy=%b a=%0d b=%0d want 1/0/0", if0.busy, if0.a, if0.b);
      end
      run_to_done0(cyc);
      total++;
      if (cyc !== 128) begin
         bad++; $display("FAIL good_cycles got=%0d want=128", cyc);
      end
      total++;
      if ({if0.done, if0.pass, if0.busy} !== 3'b110 || if0.err_count !== 7'd0 || if0.first_fail !== 6'd0) begin
         bad++; $display("FAIL good_result dpb=%b err=%0d ff=%0d want 110/0/0", {if0.done, if0.pass, if0.busy}, if0.err_count, if0.first_fail);
      end
   endtask

   task automatic test_fault_sweep();
      int cyc;
      fault = 1'b1;
      pulse_start0();
      run_to_done0(cyc);
`ifdef ADD_CHK_STOP_ON_FAIL_EN
      total++;
      if (cyc !== 32) begin bad++; $display("FAIL fault_cycles got=%0d want=32", cyc); end
      total++;
      if (if0.err_count !== 7'd1) begin bad++; $display("FAIL fault_err got=%0d want=1", if0.err_count); end
      total++;
      if (if0.a !== 3'd7 || if0.b !== 3'd1) begin bad++; $display("FAIL fault_hold a=%0d b=%0d want 7/1", if0.a, if0.b); end
`else
      total++;
      if (cyc !== 128) begin bad++; $display("FAIL fault_cycles got=%0d want=128", cyc); end
      total++;
      if (if0.err_count !== 7'd28) begin bad++; $display("FAIL fault_err got=%0d want=28", if0.err_count); end
      total++;
      if (if0.a !== 3'd7 || if0.b !== 3'd7) begin bad++; $display("FAIL fault_hold a=%0d b=%0d want 7/7", if0.a, if0.b); end
`endif
      total++;
      if (if0.first_fail !== 6'b111001) begin bad++; $display("FAIL fault_ff got=%b want=111001", if0.first_fail); end
      total++;
      if (if0.done !== 1'b1 || if0.pass !== 1'b0) begin bad++; $display("FAIL fault_pass done=%b pass=%b want 1/0", if0.done, if0.pass); end
      step();
      total++;
      if (if0.done !== 1'b1 || if0.first_fail !== 6'b111001) begin
         bad++; $display("FAIL done_hold done=%b ff=%b want 1/111001", if0.done, if0.first_fail);
      end
   endtask

   task automatic test_start_in_done();
      int cyc;
      fault = 1'b0;
      pulse_start0();
      total++;
      if (if0.done !== 1'b0 || if0.busy !== 1'b1 || if0.err_count !== 7'd0 || if0.first_fail !== 6'd0) begin
         bad++; $display("FAIL restart_clear done=%b busy=%b err=%0d ff=%0d want 0/1/0/0", if0.done, if0.busy, if0.err_count, if0.first_fail);
      end
      cyc = 0;
      repeat (10) begin step(); cyc++; end
      pulse_start0();
      cyc++;
      total++;
      if (if0.busy !== 1'b1 || if0.a !== 3'd5 || if0.b !== 3'd0) begin
         bad++; $display("FAIL busy_start busy=%b a=%0d b=%0d want 1/5/0", if0.busy, if0.a, if0.b);
      end
      while (!if0.done && cyc < 2000) begin step(); cyc++; end
      total++;
      if (cyc !== 128 || if0.pass !== 1'b1) begin
         bad++; $display("FAIL busy_start_len cyc=%0d pass=%b want 128/1", cyc, if0.pass);
      end
   endtask

   task automatic test_reset_mid();
      int cyc;
      pulse_start0();
      cyc = 0;
      while (!(if0.a == 3'd4 && if0.b == 3'd2) && cyc < 200) begin step(); cyc++; end
      total++;
      if (cyc >= 200) begin bad++; $display("FAIL reach_v20 timeout cyc=%0d", cyc); end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({if0.busy, if0.done, if0.pass, if0.a, if0.b, if0.err_count, if0.first_fail} !== 22'd0) begin
         bad++; $display("FAIL async_reset busy=%b a=%0d b=%0d err=%0d ff=%0d want 0", if0.busy, if0.a, if0.b, if0.err_count, if0.first_fail);
      end
      step();
      rst_n = 1'b1;
      repeat (3) step();
      total++;
      if (if0.busy !== 1'b0 || if0.done !== 1'b0) begin
         bad++; $display("FAIL post_reset_idle busy=%b done=%b want 0/0", if0.busy, if0.done);
      end
      pulse_start0();
      total++;
      if (if0.busy !== 1'b1 || if0.a !== 3'd0 || if0.b !== 3'd0) begin
         bad++; $display("FAIL resweep_v0 busy=%b a=%0d b=%0d want 1/0/0", if0.busy, if0.a, if0.b);
      end
      step();
      step();
      total++;
      if (if0.a !== 3'd1 || if0.b !== 3'd0) begin
         bad++; $display("FAIL resweep_v1 a=%0d b=%0d want 1/0", if0.a, if0.b);
      end
   endtask

   task automatic test_settle3();
      int cyc;
      if1.start = 1'b1;
      step();
      if1.start = 1'b0;
      cyc = 0;
      while (!if1.done && cyc < 2000) begin step(); cyc++; end
      total++;
      if (cyc !== 256) begin bad++; $display("FAIL settle3_cycles got=%0d want=256", cyc); end
      total++;
      if (if1.pass !== 1'b1 || if1.err_count !== 7'd0) begin
         bad++; $display("FAIL settle3_pass pass=%b err=%0d want 1/0", if1.pass, if1.err_count);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_good_sweep();
      test_fault_sweep();
      test_start_in_done();
      test_reset_mid();
      test_settle3();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
